// File: rtl/adder_chk_pkg.sv
// Shared constants and FSM state type for the adder result checker.
package adder_chk_pkg;

  localparam int unsigned VEC_TOTAL_DEF = 512;
  localparam int unsigned CNT_W_DEF     = 10;
  localparam int unsigned VEC_W         = 9;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } chk_state_e;

endpackage

// File: rtl/adder_ref_model.sv
// Combinational golden model of the 4-bit ripple adder: full sum plus per-bit carry-outs.
module adder_ref_model (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [4:0] exp_sum,
  output logic [3:0] exp_c
);

  logic cy;

  assign exp_sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

  always_comb begin
    cy    = cin;
    exp_c = '0;
    for (int i = 0; i < 4; i++) begin
      cy       = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
      exp_c[i] = cy;
    end
  end

endmodule

// File: rtl/adder_result_checker.sv
// Two-stage response checker for the 4-bit ripple adder; counts passes/fails over a sweep.
// Define CHECKER_CARRY_CHECK_EN to compare the full internal carry vector, not just c[3].
module adder_result_checker
  import adder_chk_pkg::*;
#(
  parameter int unsigned VEC_TOTAL = VEC_TOTAL_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic             cin,
  input  logic [3:0]       s,
  input  logic [3:0]       c,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
  output logic [VEC_W-1:0] first_fail,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] VecTotalC = CNT_W'(VEC_TOTAL);

  chk_state_e       state_q, state_d;
  logic             s1_valid_q;
  logic [VEC_W-1:0] s1_vec_q;
  logic [3:0]       s1_s_q;
  logic [3:0]       s1_c_q;
  logic [CNT_W-1:0] pass_q, fail_q;
  logic             err_q;
  logic [VEC_W-1:0] ff_q;

  logic [4:0]       exp_sum;
  logic [3:0]       exp_c;
  logic             mismatch;
  logic             cmp;
  logic             last_cmp;
  logic             capture;
  logic [CNT_W-1:0] cmp_cnt_next;

  // Stage 2: golden result from the captured {b,a,cin}
  adder_ref_model u_ref (
    .a       (s1_vec_q[4:1]),
    .b       (s1_vec_q[8:5]),
    .cin     (s1_vec_q[0]),
    .exp_sum (exp_sum),
    .exp_c   (exp_c)
  );

`ifdef CHECKER_CARRY_CHECK_EN
  assign mismatch = (s1_s_q != exp_sum[3:0]) || (s1_c_q != exp_c);
`else
  logic carry_unused;
  assign carry_unused = ^{exp_c, s1_c_q[2:0]};
  assign mismatch     = (s1_s_q != exp_sum[3:0]) || (s1_c_q[3] != exp_sum[4]);
`endif

  assign cmp          = s1_valid_q;
  assign cmp_cnt_next = pass_q + fail_q + CNT_W'(1);
  assign last_cmp     = cmp && (cmp_cnt_next == VecTotalC);
  // Once the final vector is being compared, nothing further may enter stage 1
  assign capture      = in_valid && !clr && (state_q != StDone) && !last_cmp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StRun;
      StRun:   if (last_cmp) state_d = StDone;
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
    if (clr) state_d = StIdle;
  end

  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_vec_q   <= '0;
      s1_s_q     <= '0;
      s1_c_q     <= '0;
    end else begin
      s1_valid_q <= capture;
      if (capture) begin
        s1_vec_q <= {b, a, cin};
        s1_s_q   <= s;
        s1_c_q   <= c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_q <= '0;
      fail_q <= '0;
      err_q  <= 1'b0;
      ff_q   <= '0;
    end else if (clr) begin
      pass_q <= '0;
      fail_q <= '0;
      err_q  <= 1'b0;
      ff_q   <= '0;
    end else if (cmp) begin
      if (mismatch) begin
        fail_q <= fail_q + CNT_W'(1);
        if (!err_q) begin
          err_q <= 1'b1;
          ff_q  <= s1_vec_q;
        end
      end else begin
        pass_q <= pass_q + CNT_W'(1);
      end
    end
  end

  assign pass_cnt   = pass_q;
  assign fail_cnt   = fail_q;
  assign err        = err_q;
  assign first_fail = ff_q;

endmodule
